// File: rtl/rot_demux_n.sv
// -----------------------------------------------------------------------------
// rot_demux_n
//
// Purpose:
//   Rotating demultiplexer. A DATA_W-bit input word is steered to one of N_CH
//   output slots selected by a registered channel pointer. The pointer steps
//   up or down to the next enabled channel on request, skipping channels
//   whose enable bit is clear. It can also be loaded directly. A one-cycle
//   wrap pulse marks a step that crossed the channel boundary.
//
// Parameters:
//   N_CH    number of output channels (2..16)
//   DATA_W  width of d and of each output slot
//   SEL_W   pointer width, 2**SEL_W >= N_CH
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-low reset
//   d        in   [DATA_W-1:0] data to route
//   s        in   step request
//   dir      in   step direction, 0 = up, 1 = down
//   ld       in   load request (has priority over s)
//   ld_idx   in   [SEL_W-1:0] load target, ignored when >= N_CH
//   en_mask  in   [N_CH-1:0] per-channel enable
//   q        out  [N_CH*DATA_W-1:0] slot i = q[i*DATA_W +: DATA_W]
//   sel      out  [SEL_W-1:0] current pointer (registered)
//   wrap     out  registered one-cycle boundary-crossing pulse
//
// Build option:
//   ROT_DEMUX_REG_OUT_EN  when defined, q is registered and lags sel/d by
//                         one cycle; q is cleared by reset.
// -----------------------------------------------------------------------------
module rot_demux_n #(
  parameter int N_CH   = 3,
  parameter int DATA_W = 1,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        d,
  input  logic                     s,
  input  logic                     dir,
  input  logic                     ld,
  input  logic [SEL_W-1:0]         ld_idx,
  input  logic [N_CH-1:0]          en_mask,
  output logic [N_CH*DATA_W-1:0]   q,
  output logic [SEL_W-1:0]         sel,
  output logic                     wrap
);

  // Channel count at pointer width + 1 so range compares need no extension.
  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

  logic [SEL_W-1:0]       r_sel;
  logic                   r_wrap;
  logic [SEL_W-1:0]       w_sel_nxt;
  logic                   w_wrap_nxt;
  logic                   w_sel_ok;
  logic                   w_ld_ok;
  logic                   w_cur_en;
  logic                   w_found;
  logic [SEL_W-1:0]       w_found_idx;
  logic [N_CH*DATA_W-1:0] w_q;

  assign w_sel_ok = ({1'b0, r_sel} < N_CH_W);
  assign w_ld_ok  = ({1'b0, ld_idx} < N_CH_W);
  assign w_cur_en = w_sel_ok ? en_mask[r_sel] : 1'b0;

  // Search outward from the pointer for the nearest other enabled channel.
  always_comb begin
    w_found     = 1'b0;
    w_found_idx = r_sel;
    for (int k = 1; k < N_CH; k++) begin : g_srch
      int cand;
      if (dir) begin
        cand = (int'(r_sel) + N_CH - k) % N_CH;
      end else begin
        cand = (int'(r_sel) + k) % N_CH;
      end
      if (!w_found && en_mask[cand]) begin
        w_found     = 1'b1;
        w_found_idx = SEL_W'(cand);
      end else begin
        w_found     = w_found;
        w_found_idx = w_found_idx;
      end
    end
  end

  // Next pointer and wrap: defensive clear, then load, then step, else hold.
  always_comb begin
    w_sel_nxt  = r_sel;
    w_wrap_nxt = 1'b0;
    if (!w_sel_ok) begin
      w_sel_nxt  = {SEL_W{1'b0}};
      w_wrap_nxt = 1'b0;
    end else if (ld) begin
      if (w_ld_ok) begin
        w_sel_nxt = ld_idx;
      end else begin
        w_sel_nxt = r_sel;
      end
      w_wrap_nxt = 1'b0;
    end else if (s) begin
      if (w_found) begin
        w_sel_nxt = w_found_idx;
        // Moving up onto a lower-or-equal index (or down onto a higher one)
        // means the boundary was crossed.
        if (dir) begin
          w_wrap_nxt = (w_found_idx >= r_sel);
        end else begin
          w_wrap_nxt = (w_found_idx <= r_sel);
        end
      end else if (w_cur_en) begin
        // Only the current channel is enabled: a full lap back to itself.
        w_sel_nxt  = r_sel;
        w_wrap_nxt = 1'b1;
      end else begin
        w_sel_nxt  = r_sel;
        w_wrap_nxt = 1'b0;
      end
    end else begin
      w_sel_nxt  = r_sel;
      w_wrap_nxt = 1'b0;
    end
  end

  // Pointer and wrap registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel  <= {SEL_W{1'b0}};
      r_wrap <= 1'b0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  // Combinational slot steering: only the selected, enabled slot carries d.
  always_comb begin
    w_q = {(N_CH*DATA_W){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if ((SEL_W'(i) == r_sel) && en_mask[i]) begin
        w_q[i*DATA_W +: DATA_W] = d;
      end else begin
        w_q[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

`ifdef ROT_DEMUX_REG_OUT_EN
  logic [N_CH*DATA_W-1:0] r_q;

  // Output register for q, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= {(N_CH*DATA_W){1'b0}};
    end else begin
      r_q <= w_q;
    end
  end

  assign q = r_q;
`else
  assign q = w_q;
`endif

  assign sel  = r_sel;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_rot_demux_n.sv
// -----------------------------------------------------------------------------
// tb_rot_demux_n
//
// Self-checking bench for rot_demux_n (N_CH=3, DATA_W=4, SEL_W=2). A
// behavioural model tracks the pointer as "move k positions until an enabled
// channel is hit" and flags wrap when the unwrapped position leaves 0..N_CH-1.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_rot_demux_n;

  localparam int N_CH   = 3;
  localparam int DATA_W = 4;
  localparam int SEL_W  = 2;
  localparam int QW     = N_CH * DATA_W;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] d;
  logic              s;
  logic              dir;
  logic              ld;
  logic [SEL_W-1:0]  ld_idx;
  logic [N_CH-1:0]   en_mask;
  logic [QW-1:0]     q;
  logic [SEL_W-1:0]  sel;
  logic              wrap;

  int n_checks;
  int n_fail;

  // model state
  int            m_sel;
  int            m_wrap;
  logic [QW-1:0] m_rq;

  rot_demux_n #(.N_CH(N_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .s       (s),
    .dir     (dir),
    .ld      (ld),
    .ld_idx  (ld_idx),
    .en_mask (en_mask),
    .q       (q),
    .sel     (sel),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [QW-1:0] slot_q(input int p, input logic [N_CH-1:0] m, input logic [DATA_W-1:0] dd);
    logic [QW-1:0] r;
    r = '0;
    if (m[p]) r[p*DATA_W +: DATA_W] = dd;
    return r;
  endfunction

  // Model of one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [QW-1:0] before_q;
    int k_hit;
    before_q = slot_q(m_sel, en_mask, d);
    if (!rst) begin
      m_sel  = 0;
      m_wrap = 0;
      m_rq   = '0;
    end else begin
      m_rq = before_q;
      if (ld) begin
        if (int'(ld_idx) < N_CH) m_sel = int'(ld_idx);
        m_wrap = 0;
      end else if (s) begin
        k_hit = 0;
        // distance N_CH lands back on the current channel (full lap)
        for (int k = 1; k <= N_CH; k++) begin
          int pos;
          pos = dir ? m_sel - k : m_sel + k;
          if (k_hit == 0 && en_mask[((pos % N_CH) + N_CH) % N_CH]) k_hit = k;
        end
        if (k_hit == 0) begin
          m_wrap = 0;
        end else begin
          int pos;
          pos    = dir ? m_sel - k_hit : m_sel + k_hit;
          m_wrap = (pos < 0 || pos >= N_CH) ? 1 : 0;
          m_sel  = ((pos % N_CH) + N_CH) % N_CH;
        end
      end else begin
        m_wrap = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [SEL_W-1:0] li,
                     input logic st, input logic dr, input logic [N_CH-1:0] m,
                     input logic [DATA_W-1:0] dd);
    rst = r; ld = l; ld_idx = li; s = st; dir = dr; en_mask = m; d = dd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("sel", 32'(sel), 32'(m_sel));
    check_val("wrap", 32'(wrap), 32'(m_wrap));
`ifdef ROT_DEMUX_REG_OUT_EN
    check_val("q", 32'(q), 32'(m_rq));
`else
    check_val("q", 32'(q), 32'(slot_q(m_sel, en_mask, d)));
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_sel    = 0;
    m_wrap   = 0;
    m_rq     = '0;
    rst = 1'b0; ld = 1'b0; ld_idx = '0; s = 1'b0; dir = 1'b0; en_mask = '1; d = 4'h1;

    // Reset
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b111, 4'h1);
    check_val("rst_sel", 32'(sel), 32'd0);
    check_val("rst_wrap", 32'(wrap), 32'd0);
`ifdef ROT_DEMUX_REG_OUT_EN
    check_val("rst_q", 32'(q), 32'h000);
`else
    check_val("rst_q", 32'(q), 32'h001);
`endif

    // Rotation up: 1, 2, 0 with wrap on the return to 0
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'b111, 4'h1);
    check_val("up1_sel", 32'(sel), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'b111, 4'h1);
    check_val("up2_sel", 32'(sel), 32'd2);
    check_val("up2_wrap", 32'(wrap), 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'b111, 4'h1);
    check_val("up3_sel", 32'(sel), 32'd0);
    check_val("up3_wrap", 32'(wrap), 32'd1);

    // Skip over masked channel 1, downwards then upwards
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 3'b101, 4'h1);
    check_val("dn1_sel", 32'(sel), 32'd2);
    check_val("dn1_wrap", 32'(wrap), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 3'b101, 4'h1);
    check_val("dn2_sel", 32'(sel), 32'd0);
    check_val("dn2_wrap", 32'(wrap), 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'b101, 4'h1);
    check_val("skipup_sel", 32'(sel), 32'd2);
    check_val("skipup_wrap", 32'(wrap), 32'd0);

    // Load beats step; out-of-range load ignored
    cyc(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'b111, 4'h1);
    cyc(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 3'b111, 4'h1);
    check_val("ld_sel", 32'(sel), 32'd2);
    check_val("ld_wrap", 32'(wrap), 32'd0);
    cyc(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 3'b111, 4'h1);
    check_val("ldoor_sel", 32'(sel), 32'd2);

    // Masked selected slot and all-zero mask
    cyc(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'b101, 4'h1);
    check_val("mask_sel", 32'(sel), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'b000, 4'h1);
    check_val("zmask_sel", 32'(sel), 32'd1);
    check_val("zmask_wrap", 32'(wrap), 32'd0);
    // Only the current channel enabled: full lap
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 3'b010, 4'h9);
    check_val("lap_sel", 32'(sel), 32'd1);
    check_val("lap_wrap", 32'(wrap), 32'd1);

    // Mid-operation reset beats load and step
    cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'b111, 4'h1);
    cyc(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 3'b111, 4'h1);
    check_val("mrst_sel", 32'(sel), 32'd0);
    check_val("mrst_wrap", 32'(wrap), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic          r_r, r_l, r_s, r_d;
      logic [1:0]    r_li;
      logic [2:0]    r_m;
      logic [3:0]    r_dd;
      r_r  = ($urandom_range(0, 99) >= 3);
      r_l  = ($urandom_range(0, 99) < 15);
      r_li = 2'($urandom_range(0, 3));
      r_s  = ($urandom_range(0, 99) < 65);
      r_d  = 1'($urandom_range(0, 1));
      r_m  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : en_mask;
      r_dd = 4'($urandom_range(0, 15));
      cyc(r_r, r_l, r_li, r_s, r_d, r_m, r_dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
